// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the data RAM and ram_arbiter.
// Signal names carry the arbiter's point of view (_i into the arbiter, _o out of it).
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req_i;
  logic          m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i;
  logic          m0_gnt_o;
  logic          m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;

  logic          m1_req_i;
  logic          m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m1_lock_i;
  logic          m1_gnt_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;

  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_data_i;

  logic          locked_o;
  logic          dbg_prio_o;
  logic          dbg_cool_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_we_o, ram_addr_o, ram_data_o,
    input  ram_data_i,
    output locked_o, dbg_prio_o, dbg_cool_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_we_o, ram_addr_o, ram_data_o,
    output ram_data_i,
    input  locked_o, dbg_prio_o, dbg_cool_o
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving the core LSU (m0) and the debug loader (m1) one RAM access
// per cycle; m1 can lock the RAM for bounded bursts. Read data returns one cycle after grant.
module ram_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rstn,
  ram_arbiter_if.slave  bus
);

  // Handshake: a master raises req with a stable cmd (we/addr/wdata) and holds both until
  // gnt is high in the same cycle; the RAM access happens in that cycle and the master's
  // rvalid is high for exactly the following cycle (rdata meaningful only for reads).

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;   // 0: m0 wins a tie, 1: m1 wins a tie
  logic          cool_q, cool_d;   // set after a lock timeout, blocks immediate re-lock
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      if (state_q == ST_LOCK) begin
        gnt1 = bus.m1_req_i;
      end else if (bus.m0_req_i && bus.m1_req_i) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = bus.m0_req_i;
        gnt1 = bus.m1_req_i;
      end
    end
  end

  assign bus.m0_gnt_o   = gnt0;
  assign bus.m1_gnt_o   = gnt1;
  assign bus.ram_we_o   = gnt1 ? bus.m1_we_i    : (gnt0 & bus.m0_we_i);
  assign bus.ram_addr_o = gnt1 ? bus.m1_addr_i  : bus.m0_addr_i;
  assign bus.ram_data_o = gnt1 ? bus.m1_wdata_i : bus.m0_wdata_i;
  assign bus.locked_o   = (state_q == ST_LOCK);
  assign bus.dbg_prio_o = prio_q;
  assign bus.dbg_cool_o = cool_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cool_d  = cool_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARB: begin
        if (gnt0)      prio_d = 1'b1;
        else if (gnt1) prio_d = 1'b0;
        if (gnt0 || !bus.m0_req_i) cool_d = 1'b0;
        // Lock entry looks at the registered cool flag, so the clearing cycle itself cannot lock.
        if (gnt1 && bus.m1_lock_i && !cool_q) begin
          state_d = ST_LOCK;
          cnt_d   = CW'(1);
        end
      end
      ST_LOCK: begin
        if (cnt_q == CW'(LOCK_MAX)) begin
          state_d = ST_ARB;
          prio_d  = 1'b0;
          cool_d  = 1'b1;
          cnt_d   = '0;
        end else if (!bus.m1_lock_i) begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_ARB;
      prio_q  <= 1'b0;
      cool_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cool_q  <= cool_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.m0_rvalid_o <= 1'b0;
      bus.m1_rvalid_o <= 1'b0;
      bus.m0_rdata_o  <= '0;
      bus.m1_rdata_o  <= '0;
    end else begin
      bus.m0_rvalid_o <= gnt0;
      bus.m1_rvalid_o <= gnt1;
      if (gnt0 && !bus.m0_we_i) bus.m0_rdata_o <= bus.ram_data_i;
      if (gnt1 && !bus.m1_we_i) bus.m1_rdata_o <= bus.ram_data_i;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic, all checked against a
// cycle-level reference model of the arbitration rules with its own copy of RAM contents.
module tb_ram_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // RAM device: combinational read, written by the bench just after each rising edge
  logic [DW-1:0] ram_mem [64];
  assign bus.ram_data_i = ram_mem[bus.ram_addr_o[7:2]];

  // reference model
  logic [DW-1:0] ref_mem [64];
  bit            m_locked, m_prio, m_cool, m_rv0, m_rv1;
  int            m_lcyc;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  bit            last_g0, last_g1;

  // observations from the last step
  logic obs_g0, obs_g1, obs_lk, obs_rv0, obs_rv1, obs_we;
  logic [DW-1:0] obs_rd0, obs_rd1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_lcyc = 0; m_prio = 0; m_cool = 0;
    m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  // One clock cycle: check at the falling edge, advance the model, write the RAM after the edge.
  task automatic step();
    bit g0, g1, enter;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, v;
    logic          cap_we;
    logic [5:0]    cap_idx;
    logic [DW-1:0] cap_data;
    @(negedge clk);
    g0 = 0; g1 = 0;
    if (rstn) begin
      if (m_locked) g1 = bus.m1_req_i;
      else if (bus.m0_req_i && bus.m1_req_i) begin
        if (m_prio) g1 = 1; else g0 = 1;
      end else begin
        g0 = bus.m0_req_i; g1 = bus.m1_req_i;
      end
    end
    e_we   = (g0 && bus.m0_we_i) || (g1 && bus.m1_we_i);
    e_addr = g1 ? bus.m1_addr_i  : bus.m0_addr_i;
    e_data = g1 ? bus.m1_wdata_i : bus.m0_wdata_i;

    obs_g0 = bus.m0_gnt_o;     obs_g1 = bus.m1_gnt_o;   obs_lk = bus.locked_o;
    obs_rv0 = bus.m0_rvalid_o; obs_rv1 = bus.m1_rvalid_o;
    obs_rd0 = bus.m0_rdata_o;  obs_rd1 = bus.m1_rdata_o; obs_we = bus.ram_we_o;

    check("m0_gnt", DW'(obs_g0), DW'(g0));
    check("m1_gnt", DW'(obs_g1), DW'(g1));
    check("ram_we", DW'(obs_we), DW'(e_we));
    check("ram_addr", bus.ram_addr_o, e_addr);
    if (e_we) check("ram_data", bus.ram_data_o, e_data);
    check("locked", DW'(obs_lk), DW'(m_locked));
    check("prio", DW'(bus.dbg_prio_o), DW'(m_prio));
    check("cool", DW'(bus.dbg_cool_o), DW'(m_cool));
    check("m0_rvalid", DW'(obs_rv0), DW'(m_rv0));
    check("m1_rvalid", DW'(obs_rv1), DW'(m_rv1));
    if (m_rv0 && exp_q0.size() > 0) begin v = exp_q0.pop_front(); check("m0_rdata", obs_rd0, v); end
    if (m_rv1 && exp_q1.size() > 0) begin v = exp_q1.pop_front(); check("m1_rdata", obs_rd1, v); end

    cap_we = bus.ram_we_o; cap_idx = bus.ram_addr_o[7:2]; cap_data = bus.ram_data_o;

    if (!rstn) begin
      model_reset();
    end else begin
      m_rv0 = g0; m_rv1 = g1;
      if (g0) begin
        v = bus.m0_we_i ? m_rd0 : ref_mem[bus.m0_addr_i[7:2]];
        m_rd0 = v; exp_q0.push_back(v);
        if (bus.m0_we_i) ref_mem[bus.m0_addr_i[7:2]] = bus.m0_wdata_i;
      end
      if (g1) begin
        v = bus.m1_we_i ? m_rd1 : ref_mem[bus.m1_addr_i[7:2]];
        m_rd1 = v; exp_q1.push_back(v);
        if (bus.m1_we_i) ref_mem[bus.m1_addr_i[7:2]] = bus.m1_wdata_i;
      end
      if (!m_locked) begin
        enter = g1 && bus.m1_lock_i && !m_cool;
        if (g0) m_prio = 1; else if (g1) m_prio = 0;
        if (g0 || !bus.m0_req_i) m_cool = 0;
        if (enter) begin m_locked = 1; m_lcyc = 1; end
      end else if (m_lcyc == LOCK_MAX) begin
        m_locked = 0; m_lcyc = 0; m_prio = 0; m_cool = 1;
      end else if (!bus.m1_lock_i) begin
        m_locked = 0; m_lcyc = 0;
      end else begin
        m_lcyc++;
      end
    end
    last_g0 = g0; last_g1 = g1;

    @(posedge clk);
    #1;
    if (cap_we) ram_mem[cap_idx] = cap_data;
  endtask

  // driver tasks
  task automatic set_m0(input logic req, input logic we, input logic [7:0] addr, input logic [DW-1:0] wd);
    bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = AW'(addr); bus.m0_wdata_i = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [7:0] addr, input logic [DW-1:0] wd);
    bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = AW'(addr); bus.m1_wdata_i = wd;
  endtask

  task automatic rand_drive(input int lock_flip);
    if (!bus.m0_req_i || last_g0)
      set_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'b00}, $urandom);
    if (!bus.m1_req_i || last_g1)
      set_m1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'b00}, $urandom);
    if ($urandom_range(0, lock_flip - 1) == 0) bus.m1_lock_i = ~bus.m1_lock_i;
    rstn = ($urandom_range(0, 299) != 0);
  endtask

  initial begin
    int n;
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom; ram_mem[i] = v; ref_mem[i] = v;
    end
    model_reset();
    last_g0 = 0; last_g1 = 0;
    rstn = 1'b0;
    bus.m1_lock_i = 1'b0;
    set_m0(1'b1, 1'b0, 8'h10, '0);
    set_m1(1'b1, 1'b0, 8'h20, '0);

    // reset with both requesting
    step();
    step();
    check("t1_rst_gnt0", DW'(obs_g0), '0);
    check("t1_rst_gnt1", DW'(obs_g1), '0);
    check("t1_rst_we", DW'(obs_we), '0);
    check("t1_rst_rv0", DW'(obs_rv0), '0);
    check("t1_rst_rv1", DW'(obs_rv1), '0);
    check("t1_rst_rd0", obs_rd0, '0);
    rstn = 1'b1;

    // round robin with both requests held: m0, m1, m0, m1
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_gnt0", DW'(obs_g0), DW'(k % 2 == 0));
      check("t2_gnt1", DW'(obs_g1), DW'(k % 2 == 1));
      if (k > 0) check("t2_rv0", DW'(obs_rv0), DW'(k % 2 == 1));
    end
    set_m0(1'b0, 1'b0, 8'h10, '0);
    set_m1(1'b0, 1'b0, 8'h20, '0);
    step();
    check("t2_rv1_last", DW'(obs_rv1), 1);

    // write by m1, read same word by m0 on the next cycle
    set_m1(1'b1, 1'b1, 8'h40, 32'hDEADBEEF);
    step();
    check("t3_wr_gnt1", DW'(obs_g1), 1);
    set_m1(1'b0, 1'b0, 8'h40, '0);
    set_m0(1'b1, 1'b0, 8'h40, '0);
    step();
    check("t3_rd_gnt0", DW'(obs_g0), 1);
    set_m0(1'b0, 1'b0, 8'h40, '0);
    step();
    check("t3_rv0", DW'(obs_rv0), 1);
    check("t3_rdata", obs_rd0, 32'hDEADBEEF);

    // lock: m0 starved while m1 holds the lock, granted right after release
    set_m0(1'b1, 1'b0, 8'h80, '0);
    set_m1(1'b1, 1'b0, 8'h84, '0);
    bus.m1_lock_i = 1'b1;
    obs_lk = 1'b0;
    for (int i = 0; i < 6 && !obs_lk; i++) step();
    check("t4_lock_enter", DW'(obs_lk), 1);
    check("t4_m0_starved", DW'(obs_g0), '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_locked", DW'(obs_lk), 1);
      check("t4_m0_starved", DW'(obs_g0), '0);
    end
    bus.m1_lock_i = 1'b0;
    step();
    check("t4_release_cycle", DW'(obs_lk), 1);
    step();
    check("t4_m0_after", DW'(obs_g0), 1);
    check("t4_unlocked", DW'(obs_lk), '0);

    // timeout: lock held forever
    bus.m1_lock_i = 1'b1;
    obs_lk = 1'b0;
    for (int i = 0; i < 6 && !obs_lk; i++) step();
    check("t5_lock_enter", DW'(obs_lk), 1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!obs_lk) break;
      n++;
    end
    check("t5_lock_len", DW'(n), DW'(LOCK_MAX));
    check("t5_m0_after_to", DW'(obs_g0), 1);
    step();
    check("t5_m1_regnt", DW'(obs_g1), 1);
    check("t5_not_yet", DW'(obs_lk), '0);
    step();
    check("t5_relocked", DW'(obs_lk), 1);

    // reset in the middle of a lock (7th locked cycle)
    for (int i = 0; i < 5; i++) step();
    rstn = 1'b0;
    step();
    check("t6_rst_gnt1", DW'(obs_g1), '0);
    rstn = 1'b1;
    step();
    check("t6_unlocked", DW'(obs_lk), '0);
    check("t6_m0_first", DW'(obs_g0), 1);
    check("t6_rv1_gone", DW'(obs_rv1), '0);

    // random traffic: short locks, then long locks that reach the timeout
    bus.m1_lock_i = 1'b0;
    for (int c = 0; c < 1500; c++) begin rand_drive(6);  step(); end
    for (int c = 0; c < 1500; c++) begin rand_drive(40); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
